// File: rtl/core_pkg.sv
// core_pkg: core-wide widths and memory-port limits shared by the memory blocks
package core_pkg;
   localparam int Xlen = 32;
   localparam int MaskBits = Xlen / 8;
   localparam int MemLatencyMax = 8;
endpackage

// File: rtl/resp_delay_line.sv
// resp_delay_line: valid+data shift pipeline with sync clear; data only advances with a valid beat
module resp_delay_line #(
   parameter int Width = 32,
   parameter int Depth = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [Width-1:0] data_i,
   output logic             valid_o,
   output logic [Width-1:0] data_o
);
   logic             v_q [Depth];
   logic [Width-1:0] d_q [Depth];
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < Depth; k++) begin
            v_q[k] <= 1'b0;
            d_q[k] <= '0;
         end
      end else begin
         v_q[0] <= valid_i;
         if (valid_i) d_q[0] <= data_i;
         for (int k = 1; k < Depth; k++) begin
            v_q[k] <= v_q[k-1];
            if (v_q[k-1]) d_q[k] <= d_q[k-1];
         end
      end
   end
   assign valid_o = v_q[Depth-1];
   assign data_o  = d_q[Depth-1];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: byte-maskable word SRAM behind a ready/valid/rvalid port, fixed read latency, optional busy window
module mem_responder
   import core_pkg::*;
#(
   parameter int    DataWidth  = Xlen,
   parameter int    DepthLog2  = 12,
   parameter int    Latency    = 1,
   parameter int    BusyCycles = 0,
   parameter string MemInit    = ""
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   output logic                   mem_ready_o,
   input  logic                   mem_valid_i,
   input  logic [DataWidth-1:0]   mem_addr_i,
   input  logic [DataWidth-1:0]   mem_wdata_i,
   input  logic [DataWidth/8-1:0] mem_wmask_i,
   output logic [DataWidth-1:0]   mem_rdata_o,
   output logic                   mem_rvalid_o
);
   localparam int Bytes = DataWidth / 8;
   localparam int Off   = $clog2(Bytes);
   localparam int CntW  = BusyCycles > 0 ? $clog2(BusyCycles + 1) : 1;
   if (Latency < 1 || Latency > MemLatencyMax || DataWidth % 8 != 0) begin : g_bad_cfg
      $error("mem_responder: unsupported Latency or DataWidth");
   end
   logic [DataWidth-1:0] mem [2**DepthLog2];
   logic [DepthLog2-1:0] idx;
   logic [CntW-1:0]      cnt;
   logic                 accept, rd, wr;
   logic                 unused_addr;
   assign idx         = mem_addr_i[Off +: DepthLog2];
   assign unused_addr = ^mem_addr_i;
   assign mem_ready_o = cnt == '0 && !rst_i;
   assign accept      = mem_valid_i && mem_ready_o;
   assign wr          = accept && mem_wmask_i != '0;
   assign rd          = accept && mem_wmask_i == '0;
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt <= '0;
      else if (accept) cnt <= CntW'(BusyCycles);
      else if (cnt != '0) cnt <= cnt - 1'b1;
   end
   always_ff @(posedge clk_i) begin
      if (wr) begin
         for (int k = 0; k < Bytes; k++)
            if (mem_wmask_i[k]) mem[idx][8*k +: 8] <= mem_wdata_i[8*k +: 8];
      end
   end
   resp_delay_line #(.Width(DataWidth), .Depth(Latency)) u_delay (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (rd),
      .data_i  (mem[idx]),
      .valid_o (mem_rvalid_o),
      .data_o  (mem_rdata_o)
   );
   a_wmask_known: assert property (@(posedge clk_i) disable iff (rst_i) mem_valid_i |-> !$isunknown(mem_wmask_i));
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scenario tasks plus a randomized run against a behavioural memory model
module tb_mem_responder;
   localparam int LA = 3;
   localparam int LB = 2;
   localparam int LC = 4;
   localparam int BC = 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_cmp = 0;
   int n_err = 0;
   always #5 clk = ~clk;
   logic v_a = 1'b0, v_b = 1'b0, v_c = 1'b0;
   logic [31:0] addr_a = '0, addr_b = '0, addr_c = '0;
   logic [31:0] wd_a = '0, wd_b = '0, wd_c = '0;
   logic [3:0] m_a = '0, m_b = '0, m_c = '0;
   logic rdy_a, rdy_b, rdy_c, rv_a, rv_b, rv_c;
   logic [31:0] rd_a, rd_b, rd_c;
   bit acc_c [9];
   mem_responder #(.Latency(LA)) dut_a (
      .clk_i(clk), .rst_i(rst), .mem_ready_o(rdy_a), .mem_valid_i(v_a), .mem_addr_i(addr_a),
      .mem_wdata_i(wd_a), .mem_wmask_i(m_a), .mem_rdata_o(rd_a), .mem_rvalid_o(rv_a));
   mem_responder #(.Latency(LB), .DepthLog2(4)) dut_b (
      .clk_i(clk), .rst_i(rst), .mem_ready_o(rdy_b), .mem_valid_i(v_b), .mem_addr_i(addr_b),
      .mem_wdata_i(wd_b), .mem_wmask_i(m_b), .mem_rdata_o(rd_b), .mem_rvalid_o(rv_b));
   mem_responder #(.Latency(LC), .BusyCycles(BC)) dut_c (
      .clk_i(clk), .rst_i(rst), .mem_ready_o(rdy_c), .mem_valid_i(v_c), .mem_addr_i(addr_c),
      .mem_wdata_i(wd_c), .mem_wmask_i(m_c), .mem_rdata_o(rd_c), .mem_rvalid_o(rv_c));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) begin
         step();
         n_cmp++;
         if ({rdy_a, rdy_b, rdy_c} !== 3'b000) begin n_err++; $display("FAIL reset_ready: got %b want 000", {rdy_a, rdy_b, rdy_c}); end
         n_cmp++;
         if ({rv_a, rv_b, rv_c} !== 3'b000) begin n_err++; $display("FAIL reset_rvalid: got %b want 000", {rv_a, rv_b, rv_c}); end
         n_cmp++;
         if (rd_a !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rd_a); end
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({rdy_a, rdy_b, rdy_c} !== 3'b111) begin n_err++; $display("FAIL ready_after_reset: got %b want 111", {rdy_a, rdy_b, rdy_c}); end
      repeat (20) begin
         step();
         n_cmp++;
         if ({rv_a, rv_b, rv_c} !== 3'b000) begin n_err++; $display("FAIL idle_rvalid: got %b want 000", {rv_a, rv_b, rv_c}); end
      end
   endtask

   task automatic test_write_read();
      v_a = 1'b1; addr_a = 32'h40; wd_a = 32'hDEADBEEF; m_a = 4'hF;
      step();
      m_a = 4'h0; wd_a = $urandom;
      step();
      v_a = 1'b0;
      for (int j = 0; j <= LA + 1; j++) begin
         if (j > 0) step();
         n_cmp++;
         if (rv_a !== (j == LA - 1)) begin n_err++; $display("FAIL wr_rd_rvalid j=%0d: got %b want %b", j, rv_a, j == LA - 1); end
         if (j >= LA - 1) begin
            n_cmp++;
            if (rd_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_rd_data j=%0d: got %h want deadbeef", j, rd_a); end
         end
      end
   endtask

   task automatic test_byte_mask();
      v_a = 1'b1; addr_a = 32'h8; wd_a = 32'h11223344; m_a = 4'hF;
      step();
      wd_a = 32'hAABBCCDD; m_a = 4'b0101;
      step();
      m_a = 4'h0; wd_a = '0;
      step();
      v_a = 1'b0;
      for (int j = 0; j <= LA; j++) begin
         if (j > 0) step();
         n_cmp++;
         if (rv_a !== (j == LA - 1)) begin n_err++; $display("FAIL mask_rvalid j=%0d: got %b want %b", j, rv_a, j == LA - 1); end
         if (j == LA - 1) begin
            n_cmp++;
            if (rd_a !== 32'h11BB33DD) begin n_err++; $display("FAIL mask_data: got %h want 11bb33dd", rd_a); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp [4];
      v_b = 1'b1; m_b = 4'hF;
      for (int k = 0; k < 4; k++) begin
         exp[k] = $urandom;
         addr_b = 32'(4 * k); wd_b = exp[k];
         step();
      end
      m_b = 4'h0;
      for (int j = 0; j < LB + 4; j++) begin
         v_b = j < 4;
         addr_b = 32'(4 * j);
         step();
         n_cmp++;
         if (rv_b !== (j >= LB - 1 && j < LB + 3)) begin n_err++; $display("FAIL b2b_rvalid j=%0d: got %b want %b", j, rv_b, j >= LB - 1 && j < LB + 3); end
         if (j >= LB - 1 && j < LB + 3) begin
            n_cmp++;
            if (rd_b !== exp[j-LB+1]) begin n_err++; $display("FAIL b2b_data j=%0d: got %h want %h", j, rd_b, exp[j-LB+1]); end
         end
      end
      v_b = 1'b0;
   endtask

   task automatic test_wrap();
      logic [31:0] d;
      d = $urandom;
      v_b = 1'b1; addr_b = 32'h40; wd_b = d; m_b = 4'hF;
      step();
      addr_b = 32'h0; m_b = 4'h0;
      step();
      v_b = 1'b0;
      for (int j = 0; j <= LB; j++) begin
         if (j > 0) step();
         n_cmp++;
         if (rv_b !== (j == LB - 1)) begin n_err++; $display("FAIL wrap_rvalid j=%0d: got %b want %b", j, rv_b, j == LB - 1); end
         if (j == LB - 1) begin
            n_cmp++;
            if (rd_b !== d) begin n_err++; $display("FAIL wrap_data: got %h want %h", rd_b, d); end
         end
      end
   endtask

   task automatic read_c(input int w, input logic [31:0] exp, input string tag);
      n_cmp++;
      if (rdy_c !== 1'b1) begin n_err++; $display("FAIL %s_ready w=%0d: got %b want 1", tag, w, rdy_c); end
      v_c = 1'b1; addr_c = 32'(4 * w); m_c = 4'h0;
      step();
      v_c = 1'b0;
      for (int j = 0; j <= LC; j++) begin
         if (j > 0) step();
         n_cmp++;
         if (rv_c !== (j == LC - 1)) begin n_err++; $display("FAIL %s_rvalid w=%0d j=%0d: got %b want %b", tag, w, j, rv_c, j == LC - 1); end
         if (j == LC - 1) begin
            n_cmp++;
            if (rd_c !== exp) begin n_err++; $display("FAIL %s_data w=%0d: got %h want %h", tag, w, rd_c, exp); end
         end
      end
   endtask

   task automatic test_busy();
      int last_acc;
      bit exp_r;
      for (int w = 0; w < 9; w++) begin
         v_c = 1'b1; addr_c = 32'(4 * w); wd_c = 32'h5000_0000 + 32'(w); m_c = 4'hF;
         step();
         v_c = 1'b0;
         repeat (BC) step();
      end
      last_acc = -100;
      v_c = 1'b1; m_c = 4'hF;
      for (int j = 0; j < 9; j++) begin
         addr_c = 32'(4 * j); wd_c = 32'hC0DE_0000 + 32'(j);
         exp_r = j - last_acc >= BC + 1;
         n_cmp++;
         if (rdy_c !== exp_r) begin n_err++; $display("FAIL busy_ready j=%0d: got %b want %b", j, rdy_c, exp_r); end
         acc_c[j] = exp_r;
         if (exp_r) last_acc = j;
         step();
      end
      v_c = 1'b0; m_c = 4'h0;
      for (int w = 0; w < 9; w++)
         read_c(w, acc_c[w] ? 32'hC0DE_0000 + 32'(w) : 32'h5000_0000 + 32'(w), "busy_rb");
   endtask

   task automatic test_reset_midflight();
      v_c = 1'b1; addr_c = 32'h4; m_c = 4'h0;
      step();
      v_c = 1'b0;
      step();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      n_cmp++;
      if (rd_c !== 32'h0) begin n_err++; $display("FAIL midflight_rdata_clear: got %h want 0", rd_c); end
      n_cmp++;
      if (rdy_c !== 1'b1) begin n_err++; $display("FAIL midflight_ready: got %b want 1", rdy_c); end
      repeat (12) begin
         step();
         n_cmp++;
         if (rv_c !== 1'b0) begin n_err++; $display("FAIL midflight_rvalid: got %b want 0", rv_c); end
      end
      read_c(1, acc_c[1] ? 32'hC0DE_0001 : 32'h5000_0001, "persist");
   endtask

   typedef struct {
      int          due;
      logic [31:0] d;
   } exp_t;

   task automatic test_random();
      logic [31:0] mdl [16];
      exp_t q [$];
      logic [31:0] last;
      bit have_last;
      bit exp_v;
      int w;
      have_last = 1'b0;
      last = '0;
      for (int t = 0; t < 420; t++) begin
         w = t < 16 ? t : $urandom_range(0, 15);
         v_a = t < 16 ? 1'b1 : (t < 400 && $urandom_range(0, 3) != 0);
         m_a = t < 16 ? 4'hF : ($urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)));
         addr_a = ($urandom & 32'hFFFF_C003) | 32'(w << 2);
         wd_a = $urandom;
         n_cmp++;
         if (rdy_a !== 1'b1) begin n_err++; $display("FAIL rnd_ready t=%0d: got %b want 1", t, rdy_a); end
         if (v_a) begin
            if (m_a == 4'h0) q.push_back('{t + LA - 1, mdl[w]});
            else for (int k = 0; k < 4; k++) if (m_a[k]) mdl[w][8*k +: 8] = wd_a[8*k +: 8];
         end
         step();
         exp_v = q.size() > 0 && q[0].due == t;
         n_cmp++;
         if (rv_a !== exp_v) begin n_err++; $display("FAIL rnd_rvalid t=%0d: got %b want %b", t, rv_a, exp_v); end
         if (exp_v) begin
            n_cmp++;
            if (rd_a !== q[0].d) begin n_err++; $display("FAIL rnd_data t=%0d: got %h want %h", t, rd_a, q[0].d); end
            last = q[0].d;
            have_last = 1'b1;
            void'(q.pop_front());
         end else if (have_last) begin
            n_cmp++;
            if (rd_a !== last) begin n_err++; $display("FAIL rnd_hold t=%0d: got %h want %h", t, rd_a, last); end
         end
      end
      v_a = 1'b0; m_a = 4'h0;
      n_cmp++;
      if (q.size() != 0) begin n_err++; $display("FAIL rnd_drain: got %0d pending want 0", q.size()); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_mask();
      test_back_to_back();
      test_wrap();
      test_busy();
      test_reset_midflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
